// File: rtl/bin2dig_writer_if.sv
// Digit-write bus between the binary-to-decimal writer and the display controller.
// The writer drives the digit strobes; the controller side issues start/value.
`timescale 1ns/1ps

interface bin2dig_writer_if #(
  parameter int VALUE_W = 27
);
  logic               start;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic [3:0]         dig;
  logic [3:0]         pos;
  logic               wr_en;
  logic               done;
  logic               overflow;

  modport master (
    input  start, value,
    output busy, dig, pos, wr_en, done, overflow
  );

  modport slave (
    output start, value,
    input  busy, dig, pos, wr_en, done, overflow
  );
endinterface

// File: rtl/bin2dig_writer.sv
// Sequential double-dabble converter that streams NDIG decimal digits to the
// display controller, least-significant position first, one write per cycle.
`timescale 1ns/1ps

module bin2dig_writer #(
  parameter int VALUE_W = 27,
  parameter int NDIG    = 8,
  parameter int MAXVAL  = 99_999_999
) (
  input logic              clock,
  input logic              reset,
  bin2dig_writer_if.master bus
);
  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(VALUE_W);
  localparam int IDX_W = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

  state_t             state, state_n;
  logic [VALUE_W-1:0] shreg, shreg_n;
  logic [BCD_W-1:0]   bcd, bcd_n, bcd_adj;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]   wr_idx, wr_idx_n;
  logic               busy, busy_n;
  logic               wr_en, wr_en_n;
  logic               done, done_n;
  logic               overflow, overflow_n;
  logic [3:0]         dig, dig_n;
  logic [3:0]         pos, pos_n;

  function automatic logic [3:0] nibble(input logic [BCD_W-1:0] b,
                                        input logic [IDX_W-1:0] i);
    nibble = 4'd0;
    for (int n = 0; n < NDIG; n++) begin
      if (i == IDX_W'(n)) nibble = b[n*4 +: 4];
    end
  endfunction

  // Per-nibble +3 correction; each nibble stays within its own 4 bits.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < NDIG; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

  // Outputs are computed from the next state so each registered output lines
  // up with the state it belongs to; the first non-overflow write therefore
  // leaves on the same edge as the final shift. wr_idx counts writes issued,
  // so an overflow entry (wr_idx=0) spends one cycle before its first write.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bcd_n      = bcd;
    bit_cnt_n  = bit_cnt;
    wr_idx_n   = wr_idx;
    busy_n     = busy;
    wr_en_n    = 1'b0;
    done_n     = 1'b0;
    overflow_n = overflow;
    dig_n      = dig;
    pos_n      = pos;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          shreg_n   = bus.value;
          busy_n    = 1'b1;
          bit_cnt_n = '0;
          wr_idx_n  = '0;
          if (bus.value > VALUE_W'(MAXVAL)) begin
            overflow_n = 1'b1;
            bcd_n      = {NDIG{4'd9}};
            state_n    = WRITE;
          end else begin
            overflow_n = 1'b0;
            bcd_n      = '0;
            state_n    = SHIFT;
          end
        end
      end

      SHIFT: begin
        bcd_n     = {bcd_adj[BCD_W-2:0], shreg[VALUE_W-1]};
        shreg_n   = {shreg[VALUE_W-2:0], 1'b0};
        bit_cnt_n = bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(VALUE_W - 1)) begin
          state_n  = WRITE;
          wr_en_n  = 1'b1;
          pos_n    = 4'd0;
          dig_n    = bcd_n[3:0];
          wr_idx_n = IDX_W'(1);
        end
      end

      WRITE: begin
        if (wr_idx == IDX_W'(NDIG)) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          wr_en_n  = 1'b1;
          pos_n    = 4'(wr_idx);
          dig_n    = nibble(bcd, wr_idx);
          wr_idx_n = wr_idx + IDX_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any conversion at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      wr_idx   <= '0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      dig      <= 4'd0;
      pos      <= 4'd0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bcd      <= bcd_n;
      bit_cnt  <= bit_cnt_n;
      wr_idx   <= wr_idx_n;
      busy     <= busy_n;
      wr_en    <= wr_en_n;
      done     <= done_n;
      overflow <= overflow_n;
      dig      <= dig_n;
      pos      <= pos_n;
    end
  end

  assign bus.busy     = busy;
  assign bus.wr_en    = wr_en;
  assign bus.done     = done;
  assign bus.overflow = overflow;
  assign bus.dig      = dig;
  assign bus.pos      = pos;
endmodule
